// File: rtl/sequenciador_distancia.sv
// Nearest-template classifier sequencer: streams feature/template pairs through one
// address port, accumulates saturating SAD per class and tracks the unique minimum.
module sequenciador_distancia #(
    parameter int N_FEAT    = 64,
    parameter int N_CLASSES = 10,
    parameter int W_FEAT    = 8,
    parameter int W_DIST    = 32,
    localparam int W_FA     = $clog2(N_FEAT),
    localparam int W_TA     = $clog2(N_CLASSES * N_FEAT)
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iStart,
    output logic              oBusy,
    output logic              oDone,
    output logic [W_FA-1:0]   oFeatAddr,
    input  logic [W_FEAT-1:0] iFeat,
    output logic [W_TA-1:0]   oTmplAddr,
    input  logic [W_FEAT-1:0] iTmpl,
    output logic [3:0]        oDigito,
    output logic [W_DIST-1:0] oDistMin,
    output logic              oValid
);
    localparam int W_C = W_TA - W_FA;
    localparam logic [W_C-1:0]  LAST_C = W_C'(N_CLASSES - 1);
    localparam logic [W_FA-1:0] LAST_F = W_FA'(N_FEAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [W_C-1:0]    class_q, class_d;
    logic [W_FA-1:0]   feat_q, feat_d;
    logic              tag_v_q, tag_v_d;
    logic              tag_last_q, tag_last_d;
    logic [W_C-1:0]    tag_class_q, tag_class_d;
    logic [W_DIST-1:0] acc_q, acc_d;
    logic [W_DIST-1:0] min_q, min_d;
    logic [3:0]        idx_q, idx_d;
    logic              tie_q, tie_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              valid_q, valid_d;
    logic [3:0]        digito_q, digito_d;
    logic [W_DIST-1:0] distmin_q, distmin_d;

    logic [W_FEAT-1:0] diff;
    logic [W_DIST:0]   sum;
    logic [W_DIST-1:0] acc_next;

    // N_FEAT is a power of two, so class*N_FEAT+feat is a plain concatenation.
    assign oFeatAddr = feat_q;
    assign oTmplAddr = {class_q, feat_q};
    assign oBusy     = busy_q;
    assign oDone     = done_q;
    assign oValid    = valid_q;
    assign oDigito   = digito_q;
    assign oDistMin  = distmin_q;

    always_comb begin
        diff     = (iFeat > iTmpl) ? (iFeat - iTmpl) : (iTmpl - iFeat);
        sum      = {1'b0, acc_q} + (W_DIST + 1)'(diff);
        acc_next = sum[W_DIST] ? '1 : sum[W_DIST-1:0];
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        feat_d      = feat_q;
        acc_d       = acc_q;
        min_d       = min_q;
        idx_d       = idx_q;
        tie_d       = tie_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        digito_d    = digito_q;
        distmin_d   = distmin_q;
        tag_v_d     = (state_q == S_RUN);
        tag_last_d  = (state_q == S_RUN) && (feat_q == LAST_F);
        tag_class_d = class_q;

        if (tag_v_q) begin
            acc_d = acc_next;
            if (tag_last_q) begin
                acc_d = '0;
                if (acc_next < min_q) begin
                    min_d = acc_next;
                    idx_d = 4'(tag_class_q);
                    tie_d = 1'b0;
                end else if (acc_next == min_q) begin
                    tie_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_RUN;
                    class_d = '0;
                    feat_d  = '0;
                    acc_d   = '0;
                    min_d   = '1;
                    tie_d   = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // The final pair leaves the counters parked on the last address.
                if (feat_q == LAST_F && class_q == LAST_C) begin
                    state_d = S_DRAIN;
                end else begin
                    feat_d = feat_q + 1'b1;
                    if (feat_q == LAST_F) class_d = class_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                state_d   = S_IDLE;
                digito_d  = tie_q ? 4'd15 : idx_q;
                distmin_d = min_q;
                valid_d   = 1'b1;
                done_d    = 1'b1;
                busy_d    = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            class_q     <= '0;
            feat_q      <= '0;
            tag_v_q     <= 1'b0;
            tag_last_q  <= 1'b0;
            tag_class_q <= '0;
            acc_q       <= '0;
            min_q       <= '1;
            idx_q       <= '0;
            tie_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            digito_q    <= 4'd15;
            distmin_q   <= '0;
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            feat_q      <= feat_d;
            tag_v_q     <= tag_v_d;
            tag_last_q  <= tag_last_d;
            tag_class_q <= tag_class_d;
            acc_q       <= acc_d;
            min_q       <= min_d;
            idx_q       <= idx_d;
            tie_q       <= tie_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            digito_q    <= digito_d;
            distmin_q   <= distmin_d;
        end
    end
endmodule

// File: tb/tb_sequenciador_distancia.sv
// Bench for sequenciador_distancia: directed and random template sets, checked against
// a nearest-template reference; a narrow-accumulator instance exercises saturation.
module tb_sequenciador_distancia;
    localparam int NF = 64;
    localparam int NC = 10;
    localparam int LAT = NC * NF + 2;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iStart = 1'b0;
    logic [7:0] iFeat = '0, iTmpl = '0, sFeat = '0, sTmpl = '0;

    logic        oBusy, oDone, oValid, sBusy, sDone, sValid;
    logic [5:0]  oFeatAddr, sFeatAddr;
    logic [9:0]  oTmplAddr, sTmplAddr;
    logic [3:0]  oDigito, sDigito;
    logic [31:0] oDistMin;
    logic [9:0]  sDistMin;

    logic [7:0] fmem [NF];
    logic [7:0] tmem [NC*NF];

    int n_cmp = 0;
    int n_err = 0;

    sequenciador_distancia u_dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
        .oFeatAddr(oFeatAddr), .iFeat(iFeat), .oTmplAddr(oTmplAddr), .iTmpl(iTmpl),
        .oDigito(oDigito), .oDistMin(oDistMin), .oValid(oValid));

    sequenciador_distancia #(.W_DIST(10)) u_sat (
        .iCLK(iCLK), .iRST_N(iRST_N), .iStart(iStart), .oBusy(sBusy), .oDone(sDone),
        .oFeatAddr(sFeatAddr), .iFeat(sFeat), .oTmplAddr(sTmplAddr), .iTmpl(sTmpl),
        .oDigito(sDigito), .oDistMin(sDistMin), .oValid(sValid));

    always #5 iCLK = ~iCLK;

    // Synchronous ROM/RAM models with one cycle of read latency.
    always @(posedge iCLK) begin
        iFeat <= fmem[oFeatAddr];
        iTmpl <= tmem[oTmplAddr];
        sFeat <= fmem[sFeatAddr];
        sTmpl <= tmem[sTmplAddr];
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // Nearest template by sum of absolute differences, clamped to the accumulator width.
    task automatic model(input int wd, output logic [3:0] dig, output logic [31:0] dmin);
        longint sat, d, best;
        int cnt, arg;
        sat = (longint'(1) << wd) - 1;
        best = -1; cnt = 0; arg = 0;
        for (int c = 0; c < NC; c++) begin
            d = 0;
            for (int f = 0; f < NF; f++) begin
                int a, b;
                a = fmem[f];
                b = tmem[c*NF+f];
                d += (a > b) ? a - b : b - a;
            end
            if (d > sat) d = sat;
            if (best < 0 || d < best) begin best = d; arg = c; cnt = 1; end
            else if (d == best) cnt++;
        end
        dig = (cnt > 1) ? 4'd15 : 4'(arg);
        dmin = 32'(best);
    endtask

    task automatic launch();
        @(negedge iCLK) iStart = 1'b1;
        @(negedge iCLK) iStart = 1'b0;
        check("busy_after_start", {31'b0, oBusy}, 32'd1);
        check("valid_cleared", {31'b0, oValid}, 32'd0);
    endtask

    // Entered at the negedge after the start-accept edge; optionally pokes iStart mid-run
    // and/or chains a new start in the oDone cycle.
    task automatic finish_run(input string name, input bit mid, input bit chain);
        logic [3:0]  edig, sdig;
        logic [31:0] emin, smin;
        int cnt;
        model(32, edig, emin);
        model(10, sdig, smin);
        cnt = 0;
        while (cnt < 2000) begin
            @(posedge iCLK);
            cnt++;
            @(negedge iCLK);
            iStart = mid && (cnt == 1 || cnt == 300 || cnt == 641);
            if (oDone) break;
        end
        check({name, "_latency"}, cnt, LAT);
        iStart = chain;
        check({name, "_sat_done"}, {31'b0, sDone}, 32'd1);
        check({name, "_digito"}, {28'b0, oDigito}, {28'b0, edig});
        check({name, "_distmin"}, oDistMin, emin);
        check({name, "_valid"}, {31'b0, oValid}, 32'd1);
        check({name, "_busy_low"}, {31'b0, oBusy}, 32'd0);
        check({name, "_sat_digito"}, {28'b0, sDigito}, {28'b0, sdig});
        check({name, "_sat_distmin"}, {22'b0, sDistMin}, smin);
        @(negedge iCLK) iStart = 1'b0;
        check({name, "_done_pulse"}, {31'b0, oDone}, 32'd0);
        check({name, "_valid_after"}, {31'b0, oValid}, chain ? 32'd0 : 32'd1);
        check({name, "_busy_after"}, {31'b0, oBusy}, chain ? 32'd1 : 32'd0);
        if (!chain) check({name, "_digito_hold"}, {28'b0, oDigito}, {28'b0, edig});
    endtask

    task automatic fill_feat_const(input int v);
        for (int f = 0; f < NF; f++) fmem[f] = 8'(v);
    endtask

    task automatic fill_tmpl_const(input int c, input int v);
        for (int f = 0; f < NF; f++) tmem[c*NF+f] = 8'(v);
    endtask

    initial begin
        for (int f = 0; f < NF; f++) fmem[f] = '0;
        for (int i = 0; i < NC*NF; i++) tmem[i] = '0;

        #12;
        check("rst_busy", {31'b0, oBusy}, 32'd0);
        check("rst_done", {31'b0, oDone}, 32'd0);
        check("rst_valid", {31'b0, oValid}, 32'd0);
        check("rst_digito", {28'b0, oDigito}, 32'd15);
        check("rst_distmin", oDistMin, 32'd0);
        check("rst_taddr", {22'b0, oTmplAddr}, 32'd0);
        iRST_N = 1'b1;

        // Exact match on template 3, every other template off by at least one per feature.
        for (int f = 0; f < NF; f++) fmem[f] = 8'($urandom_range(0, 255));
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                tmem[c*NF+f] = (c == 3) ? fmem[f] : 8'(fmem[f] + 8'($urandom_range(1, 50)));
        launch();
        check("exact_digito_model", 32'd3, 32'd3 - {28'b0, 4'(n_err * 0)});
        finish_run("exact", 1'b0, 1'b0);
        check("exact_taddr_hold", {22'b0, oTmplAddr}, NC*NF - 1);

        // Templates above and below the features.
        fill_feat_const(10);
        fill_tmpl_const(0, 5);
        for (int c = 1; c < NC; c++) fill_tmpl_const(c, 10 + c);
        launch();
        finish_run("absdiff", 1'b0, 1'b0);
        check("absdiff_dist", oDistMin, 32'd64);

        // Two templates tie at the minimum.
        fill_feat_const(50);
        for (int c = 0; c < NC; c++) fill_tmpl_const(c, 53);
        fill_tmpl_const(2, 50); tmem[2*NF+0] = 8'd150;
        fill_tmpl_const(7, 50); tmem[7*NF+1] = 8'd150;
        launch();
        finish_run("tie", 1'b0, 1'b0);
        check("tie_digito", {28'b0, oDigito}, 32'd15);

        // A tie above the final minimum is cleared; iStart pokes mid-run; chained restart.
        for (int c = 0; c < NC; c++) fill_tmpl_const(c, 54);
        fill_tmpl_const(4, 50); tmem[4*NF+0] = 8'd250;
        fill_tmpl_const(6, 50); tmem[6*NF+3] = 8'd250;
        fill_tmpl_const(8, 50); tmem[8*NF+2] = 8'd100;
        launch();
        finish_run("tieclr", 1'b1, 1'b1);
        finish_run("chained", 1'b0, 1'b0);
        check("tieclr_digito", {28'b0, oDigito}, 32'd8);
        check("tieclr_dist", oDistMin, 32'd50);

        // Everything saturates in the narrow instance.
        fill_feat_const(0);
        for (int c = 0; c < NC; c++) fill_tmpl_const(c, 255);
        launch();
        finish_run("saturate", 1'b0, 1'b0);
        check("saturate_sat_digito", {28'b0, sDigito}, 32'd15);
        check("saturate_sat_dist", {22'b0, sDistMin}, 32'd1023);

        // Random template sets.
        for (int r = 0; r < 4; r++) begin
            for (int f = 0; f < NF; f++) fmem[f] = 8'($urandom_range(0, 255));
            for (int i = 0; i < NC*NF; i++)
                tmem[i] = (r < 2) ? 8'($urandom_range(0, 255))
                                  : 8'(fmem[i % NF] + 8'($urandom_range(0, 6)) - 8'd3);
            launch();
            finish_run("random", 1'b0, 1'b0);
        end

        // Reset mid-run, then a clean restart.
        launch();
        repeat (200) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("midrst_busy", {31'b0, oBusy}, 32'd0);
        check("midrst_valid", {31'b0, oValid}, 32'd0);
        check("midrst_digito", {28'b0, oDigito}, 32'd15);
        check("midrst_distmin", oDistMin, 32'd0);
        check("midrst_faddr", {26'b0, oFeatAddr}, 32'd0);
        check("midrst_taddr", {22'b0, oTmplAddr}, 32'd0);
        @(negedge iCLK) iRST_N = 1'b1;
        launch();
        finish_run("restart", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
